// File: rtl/apb_arb_pkg.sv
// Shared types and constants for the APB round-robin arbiter.
// Defines the arbiter state encoding, the bus field widths and the timeout counter width.
package apb_arb_pkg;

    localparam int unsigned ADDR_W = 4;
    localparam int unsigned DATA_W = 8;

    typedef enum logic [1:0] {
        StIdle,
        StIssue,
        StWait,
        StResp
    } arb_state_e;

    // Counter holds 0..TIMEOUT-1; keep at least one bit so a disabled timeout stays legal.
    function automatic int unsigned cnt_width(input int unsigned timeout);
        if (timeout <= 2) begin
            return 1;
        end
        return $clog2(timeout);
    endfunction

endpackage

// File: rtl/rr_priority_picker.sv
// Combinational round-robin picker: first set request searching upward from last_i+1 with wrap.
// Produces a one-hot grant, its index and an any-request flag.
module rr_priority_picker #(
    parameter  int unsigned NREQ = 2,
    localparam int unsigned IdxW = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic [NREQ-1:0] req_i,
    input  logic [IdxW-1:0] last_i,
    output logic [NREQ-1:0] gnt_o,
    output logic [IdxW-1:0] gnt_idx_o,
    output logic            valid_o
);

    int unsigned     cand;
    logic [IdxW-1:0] cand_idx;

    always_comb begin
        gnt_o     = '0;
        gnt_idx_o = '0;
        valid_o   = 1'b0;
        cand      = 0;
        cand_idx  = '0;
        for (int unsigned k = 1; k <= NREQ; k++) begin
            cand     = (int'(last_i) + k) % NREQ;
            cand_idx = IdxW'(cand);
            if (!valid_o && req_i[cand_idx]) begin
                valid_o         = 1'b1;
                gnt_o[cand_idx] = 1'b1;
                gnt_idx_o       = cand_idx;
            end
        end
    end

endmodule

// File: rtl/apb_rr_arbiter.sv
// Round-robin arbiter sharing one APB master among NREQ requesters, one non-pipelined
// transfer at a time, with per-transfer timeout abort and a one-cycle acknowledge.
module apb_rr_arbiter
    import apb_arb_pkg::*;
#(
    parameter int unsigned NREQ    = 2,
    parameter int unsigned TIMEOUT = 16
) (
    input  logic                   Pclk,
    input  logic                   Presetn,
    input  logic [NREQ-1:0]        req_valid,
    input  logic [ADDR_W*NREQ-1:0] req_addr,
    input  logic [DATA_W*NREQ-1:0] req_wdata,
    input  logic [NREQ-1:0]        req_wr,
    output logic [NREQ-1:0]        req_ack,
    output logic [DATA_W-1:0]      req_rdata,
    output logic                   req_err,
    output logic [ADDR_W-1:0]      m_addr,
    output logic [DATA_W-1:0]      m_datain,
    output logic                   m_wr,
    output logic                   m_newd,
    input  logic [DATA_W-1:0]      m_dataout,
    input  logic                   Psel,
    input  logic                   Penable,
    input  logic                   Pready
);

    localparam int unsigned     IdxW      = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int unsigned     CntW      = cnt_width(TIMEOUT);
    localparam bit              TimeoutEn = (TIMEOUT != 0);
    localparam logic [CntW-1:0] CntLast   = TimeoutEn ? CntW'(TIMEOUT - 1) : '0;

    arb_state_e        state_q, state_d;
    logic [NREQ-1:0]   grant_q, grant_d;
    logic [IdxW-1:0]   gidx_q, gidx_d;
    logic [IdxW-1:0]   last_q, last_d;
    logic [NREQ-1:0]   ack_q, ack_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              err_q, err_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              wr_q, wr_d;
    logic [CntW-1:0]   cnt_q, cnt_d;

    logic [NREQ-1:0]   pick_gnt;
    logic [IdxW-1:0]   pick_idx;
    logic              pick_valid;
    logic [ADDR_W-1:0] addr_arr  [NREQ];
    logic [DATA_W-1:0] wdata_arr [NREQ];
    logic              xfer_done;
    logic              stall;
    logic              timeout_hit;

    for (genvar g = 0; g < NREQ; g++) begin : g_unpack
        assign addr_arr[g]  = req_addr[g*ADDR_W +: ADDR_W];
        assign wdata_arr[g] = req_wdata[g*DATA_W +: DATA_W];
    end

    rr_priority_picker #(
        .NREQ (NREQ)
    ) u_picker (
        .req_i     (req_valid),
        .last_i    (last_q),
        .gnt_o     (pick_gnt),
        .gnt_idx_o (pick_idx),
        .valid_o   (pick_valid)
    );

    assign xfer_done   = Psel & Penable & Pready;
    assign stall       = Psel & Penable & ~Pready;
    assign timeout_hit = TimeoutEn && stall && (cnt_q == CntLast);

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        gidx_d  = gidx_q;
        last_d  = last_q;
        ack_d   = '0;
        rdata_d = rdata_q;
        err_d   = err_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        wr_d    = wr_q;
        cnt_d   = cnt_q;
        m_newd  = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (pick_valid) begin
                    grant_d = pick_gnt;
                    gidx_d  = pick_idx;
                    addr_d  = addr_arr[pick_idx];
                    wdata_d = wdata_arr[pick_idx];
                    wr_d    = req_wr[pick_idx];
                    state_d = StIssue;
                end
            end
            StIssue: begin
                m_newd  = 1'b1;
                state_d = StWait;
            end
            StWait: begin
                // Holding newd keeps the master in Enable; dropping it returns the master to idle.
                m_newd = ~xfer_done & ~timeout_hit;
                if (TimeoutEn && stall) begin
                    cnt_d = cnt_q + 1'b1;
                end
                if (xfer_done) begin
                    rdata_d = wr_q ? '0 : m_dataout;
                    err_d   = 1'b0;
                    ack_d   = grant_q;
                    cnt_d   = '0;
                    state_d = StResp;
                end else if (timeout_hit) begin
                    rdata_d = '0;
                    err_d   = 1'b1;
                    ack_d   = grant_q;
                    cnt_d   = '0;
                    state_d = StResp;
                end
            end
            StResp: begin
                last_d  = gidx_q;
                rdata_d = '0;
                err_d   = 1'b0;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge Pclk or negedge Presetn) begin
        if (!Presetn) begin
            state_q <= StIdle;
            grant_q <= '0;
            gidx_q  <= '0;
            last_q  <= IdxW'(NREQ - 1);
            ack_q   <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            wr_q    <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            gidx_q  <= gidx_d;
            last_q  <= last_d;
            ack_q   <= ack_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            wr_q    <= wr_d;
            cnt_q   <= cnt_d;
        end
    end

    assign req_ack   = ack_q;
    assign req_rdata = rdata_q;
    assign req_err   = err_q;
    assign m_addr    = addr_q;
    assign m_datain  = wdata_q;
    assign m_wr      = wr_q;

endmodule

// File: doc/apb_rr_arbiter.md
Name: apb_rr_arbiter

Overview:
Round-robin arbiter that shares the single APB master between NREQ local requesters.
- Holds one granted request at a time and drives the master's command inputs (address, write data, write enable, new-data strobe).
- Detects completion or timeout from the APB bus signals.
- Returns read data plus a one-cycle acknowledge to the granted requester.
- Enforces single, non-pipelined transfers; the arbiter is idle for at least one cycle between transfers.

Parameters:
NREQ, 2, number of requesters (2..8).
TIMEOUT, 16, max Enable-phase wait cycles with Pready low before abort; 0 disables the timeout.

Ports:
Pclk  in  1  clock; all logic rising-edge.
Presetn  in  1  asynchronous active-low reset.
req_valid  in  NREQ  request pending per requester; held with its fields until its ack.
req_addr  in  4*NREQ  packed addresses; requester i in bits [4i+3:4i].
req_wdata  in  8*NREQ  packed write data; requester i in bits [8i+7:8i].
req_wr  in  NREQ  1 = write, 0 = read.
req_ack  out  NREQ  one-hot, one-cycle completion pulse.
req_rdata  out  8  read data, valid while req_ack is high (0 for writes and aborts).
req_err  out  1  high with req_ack when the transfer was aborted by timeout.
m_addr  out  4  to master Addr.
m_datain  out  8  to master datain.
m_wr  out  1  to master wr.
m_newd  out  1  to master newd.
m_dataout  in  8  from master dataout.
Psel, Penable, Pready  in  1 each  observed APB bus signals.

Behaviour:
Reset (asynchronous, any state):
- State goes to IDLE.
- All registered outputs clear to 0: req_ack, req_rdata, req_err, m_addr, m_datain, m_wr.
- m_newd is 0.
- The round-robin pointer resets so that requester 0 has top priority.
- The timeout counter clears.
- Reset mid-transfer abandons the transfer with no ack.

FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - If any req_valid is set, pick the first set bit searching from (last_grant+1) mod NREQ upward with wrap.
  - Register grant, m_addr, m_datain, m_wr from that requester's fields; go to ISSUE.
  - If no req_valid is set, stay in IDLE.
- ISSUE (1 cycle): m_newd = 1; go to WAIT unconditionally.
- WAIT:
  - m_newd = NOT(Psel & Penable & Pready) AND NOT timeout_hit. This is the only combinational path (Pready to m_newd). It keeps the master in Enable through wait states and returns it to idle after one transfer.
  - Completion cycle (Psel & Penable & Pready): capture m_dataout into req_rdata if m_wr=0, else 0; req_err <= 0; go to RESP.
  - Timeout counter increments on each cycle with Psel & Penable & !Pready.
  - timeout_hit = (count == TIMEOUT-1) & Psel & Penable & !Pready, with TIMEOUT != 0.
  - On timeout_hit: m_newd drops (master aborts to idle), req_rdata <= 0, req_err <= 1, go to RESP.
  - Counter clears on leaving WAIT.
- RESP (1 cycle): req_ack[grant] = 1 with req_rdata/req_err; update last_grant <= grant; go to IDLE. req_rdata/req_err are cleared on the next cycle.

Timing and handshake:
- Zero-wait slave: req_valid sampled in IDLE at cycle 0, ack in cycle 4. Each slave wait state adds one cycle.
- m_addr, m_datain and m_wr stay stable from ISSUE through RESP, then hold until the next grant.
- Requesters must drop req_valid in the cycle after ack. A valid still high in IDLE is a new request.
- A req_valid that deasserts before its ack is a protocol violation; behaviour is undefined and not checked.
- Simultaneous requests: exactly one grant, following the round-robin rule. A non-granted request waits with no loss.

Decomposition:
- Package apb_arb_pkg: state enum (IDLE/ISSUE/WAIT/RESP), ADDR_W=4, DATA_W=8, and a function to compute the counter width from TIMEOUT.
- Sub-module rr_priority_picker: combinational, NREQ-wide request vector plus last_grant index, producing a one-hot grant and its index.

Test Plan:
- Single read, requester 0, addr 4'h3, Pready tied 1, m_dataout=8'hA5 -> m_newd high cycles 1-2, req_ack=2'b01 at cycle 4, req_rdata=8'hA5, req_err=0.
- Single write, requester 1, addr 4'h7, wdata 8'h3C, Pready delayed 3 cycles -> m_addr=7, m_datain=3C, m_wr=1 stable; m_newd high through wait states; req_ack=2'b10 at cycle 7, req_rdata=0.
- Both requesters valid continuously -> grants alternate 0,1,0,1 over four transfers; no requester is granted twice in a row.
- Pready held 0, TIMEOUT=16 -> m_newd drops after 16 Enable cycles; req_ack pulses with req_err=1, req_rdata=0; master Psel returns to 0; the next request completes normally.
- Presetn asserted during WAIT -> all outputs 0 immediately; no ack; after release a pending request restarts from ISSUE.
- Requester keeps req_valid high after ack -> treated as a new request; with another requester pending, the other requester is granted first.
